// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the iterative RV32M divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int unsigned DIV_STEPS     = 32;
  localparam logic [31:0] DIV_Q_DIVZERO = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_INT_MIN   = 32'h8000_0000;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  // Two's complement wrap makes -0x80000000 come back as 0x80000000.
  function automatic logic [31:0] cond_neg(logic [31:0] v, logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_if;
  import div_pkg::*;

  logic        start;
  div_op_e     div_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] div_data;

  modport master (
    output start, div_op, operand_a, operand_b,
    input  busy, done, div_data
  );

  modport slave (
    input  start, div_op, operand_a, operand_b,
    output busy, done, div_data
  );

endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [31:0] rem_sh;
  logic        carry;
  logic [32:0] trial;
  logic        ge;

  // The bit shifted out of rem is the 33rd bit of the partial remainder.
  always_comb begin
    rem_sh   = {rem[30:0], quo[31]};
    carry    = rem[31];
    trial    = {1'b0, rem_sh} - {1'b0, divisor};
    ge       = carry | ~trial[32];
    rem_next = ge ? trial[31:0] : rem_sh;
    quo_next = {quo[30:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit: one quotient bit per cycle, sign fix-up on completion.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  div_op_e         op_q, op_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            acc_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_rem, step_quo;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    acc_signed = op_is_signed(bus.div_op);
    a_mag      = cond_neg(bus.operand_a, acc_signed & bus.operand_a[31]);
    b_mag      = cond_neg(bus.operand_b, acc_signed & bus.operand_b[31]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    data_d    = data_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          op_d      = bus.div_op;
          rem_d     = '0;
          quo_d     = a_mag;
          divisor_d = b_mag;
          q_neg_d   = acc_signed & (bus.operand_a[31] ^ bus.operand_b[31]);
          r_neg_d   = acc_signed & bus.operand_a[31];
          cnt_d     = '0;
          busy_d    = 1'b1;
          // Degenerate cases bypass the iteration and resolve in one cycle.
          if (bus.operand_b == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            data_d  = op_is_rem(bus.div_op) ? bus.operand_a : DIV_Q_DIVZERO;
          end else if (acc_signed && bus.operand_a == DIV_INT_MIN &&
                       bus.operand_b == '1) begin
            state_d = DONE;
            done_d  = 1'b1;
            data_d  = op_is_rem(bus.div_op) ? '0 : DIV_INT_MIN;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_STEPS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          data_d  = op_is_rem(op_q) ? cond_neg(step_rem, r_neg_q)
                                    : cond_neg(step_quo, q_neg_q);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op_q      <= DIV;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_data = data_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider executing the RV32M DIV, DIVU, REM and REMU operations. It is the multi-cycle companion to the single-cycle ALU in the execute stage. The execute stage issues one operation with a start pulse, stalls while `busy` is high, and captures `div_data` on `done`. Algorithm: radix-2 restoring division on operand magnitudes, one quotient bit per cycle, with a sign fix-up at the end.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `div_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `operand_a`  in  32  dividend; sampled with `start`.
- `operand_b`  in  32  divisor; sampled with `start`.
- `busy`  out  1  high in CALC and DONE states.
- `done`  out  1  one-cycle pulse; `div_data` is valid in this cycle.
- `div_data`  out  32  quotient or remainder; registered and held until the next accepted result.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE and sets `busy`=0, `done`=0, `div_data`=0, step counter 0 and all datapath registers 0.
- IDLE with `start`=1 accepts the request and latches `div_op`.
  - Signed ops: latch |a| and |b|. Record `q_neg` = a[31]^b[31] and `r_neg` = a[31].
  - Unsigned ops: latch a and b as-is, with `q_neg` = `r_neg` = 0.
- Special cases are detected at accept and go straight to DONE, skipping CALC:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = operand_a. Applies to both signed and unsigned ops.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV or REM): quotient 0x80000000, remainder 0.
- CALC runs 32 steps, counter 0..31. Each step:
  - Shift the {rem, quo} pair left by one.
  - Compute trial = rem − divisor as a 33-bit subtraction.
  - If trial is non-negative, set rem = trial[31:0] and quo[0] = 1.
  - On the edge that ends step 31, go to DONE.
- DONE: on entry, `div_data` is loaded with the final value.
  - DIV/DIVU: quo, negated (two's complement) if `q_neg`.
  - REM/REMU: rem, negated if `r_neg`.
  - `done`=1 for exactly this one cycle, then unconditionally to IDLE.
- `start` in CALC or DONE is ignored: no queuing and no effect on the current operation.
- `operand_a`, `operand_b` and `div_op` may change freely after the accept cycle.
- `rst` mid-operation aborts: IDLE on the next cycle, no `done` pulse, `div_data`=0.
- Negating |0x80000000| must yield 0x80000000. This is handled by 32-bit wrap; no 33-bit result is produced.

## Timing
- Accept cycle = cycle 0. Normal path: CALC in cycles 1–32, DONE in cycle 33 (`done`=1 and `div_data` valid in cycle 33).
- Special-case path: DONE in cycle 1.
- `busy` is 0 in cycle 0 and 1 from cycle 1 through the DONE cycle inclusive.
- The earliest next accept is the cycle after DONE (cycle 34, or cycle 2 on the special-case path).
- Outputs come directly from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `div_pkg` holds:
  - `div_op_e` (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11).
  - `div_state_e` (IDLE, CALC, DONE).
  - Constants `DIV_STEPS`=32, `DIV_Q_DIVZERO`=32'hFFFFFFFF, `DIV_INT_MIN`=32'h80000000.
- One sub-module, `div_step`: a combinational single restoring step. Inputs rem, quo, divisor; outputs next rem and quo. Instantiated once inside `div_unit`.
- The FSM, counter, sign logic and output register live in `div_unit`.

## Test plan
- DIV a=0xFFFFFFF9 (−7), b=2 -> `done` in cycle 33, `div_data`=0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1).
- DIVU a=0xFFFFFFFF, b=3 -> 0x55555555. REMU a=100, b=7 -> 2. `busy` is high for exactly 33 cycles in each case.
- Divide by zero, b=0:
  - DIVU a=5 -> `done` in cycle 1, 0xFFFFFFFF.
  - REM a=0xFFFFFFFB -> 0xFFFFFFFB.
  - DIV a=0 -> 0xFFFFFFFF.
- Overflow a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000 and REM -> 0, both with `done` in cycle 1. DIVU with the same operands -> 0 after the full 33 cycles.
- Start DIV 20/3, pulse `start` with different operands in cycles 5 and 33 -> a single `done` in cycle 33 with 6. A `start` in cycle 34 is accepted normally.
- Start DIVU 1000/10 and assert `rst` in cycle 12 -> from cycle 13 `busy`=0, `done`=0, `div_data`=0, and no `done` ever appears. A new request after reset completes correctly with 100.
